fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the control/decode stage and consumes its 2-bit PC-select output.
- Holds the program counter and issues word fetches to a synchronous-read instruction memory.
- Buffers returned instructions, each with its PC, in a small FIFO and presents them to decode through a valid/ready handshake.
- Applies redirects (branch taken, jump, register-indirect jump) when decode accepts an instruction whose decoded pc_src is non-zero, flushing wrong-path work.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side bus of the fetch stage
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [1:0]            pc_src;
    logic [ADDR_WIDTH-1:0] imm_op;
    logic [ADDR_WIDTH-1:0] alu_result;
    logic                  misalign_o;

    modport master (
        output imem_req, imem_addr, instr_o, pc_o, valid_o, misalign_o,
        input  imem_rdata, ready_i, pc_src, imm_op, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, instr_o, pc_o, valid_o, misalign_o,
        output imem_rdata, ready_i, pc_src, imm_op, alu_result
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request issue, instruction buffer and redirect handling
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, raw, target;
    logic                  inflight_q, misalign_q, misalign_d;
    logic                  accept, redirect, push, issue;
    logic [PW+1:0]         occupancy;

    // Handshake, redirect target and next-state; misalignment is judged on the unmasked target
    always_comb begin
        accept     = (count_q != '0) & bus.ready_i;
        redirect   = accept & (bus.pc_src != 2'b00);
        raw        = bus.pc_src == 2'b01 ? pc_q[head_q] + bus.imm_op :
                     bus.pc_src == 2'b10 ? bus.imm_op : bus.alu_result;
        target     = {raw[ADDR_WIDTH-1:2], 2'b00};
        occupancy  = {1'b0, count_q} + (PW+2)'(inflight_q) - (PW+2)'(accept);
        issue      = ~rst & ~redirect & (occupancy < (PW+2)'(DEPTH));
        push       = inflight_q & ~redirect;
        fetch_pc_d = redirect ? target : issue ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
        head_d     = redirect ? '0 : accept ? head_q + PW'(1) : head_q;
        tail_d     = redirect ? '0 : push ? tail_q + PW'(1) : tail_q;
        count_d    = redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(accept);
        misalign_d = redirect & (raw[1:0] != 2'b00);
    end

    // Control state: PC, buffer pointers, in-flight flag and misalign pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= issue;
            misalign_q <= misalign_d;
        end
    end

    // Buffer storage and the address of the outstanding request; contents are qualified by count
    always_ff @(posedge clk) begin
        req_pc_q <= fetch_pc_q;
        if (push) begin
            instr_q[tail_q] <= bus.imem_rdata;
            pc_q[tail_q]    <= req_pc_q;
        end
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.instr_o    = instr_q[head_q];
    assign bus.pc_o       = pc_q[head_q];
    assign bus.valid_o    = count_q != '0;
    assign bus.misalign_o = misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against an architectural PC-stream model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read instruction memory
    always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem_f(bus.imem_addr);

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_pc, tgt, exp_fetch, held_pc, held_instr;
    logic exp_mis, held;
    int since, stall_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ready_i = 1'b0;
        bus.pc_src = 2'b00;
        bus.imm_op = '0;
        bus.alu_result = '0;
        #1;
        check("req_in_rst", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("rst_misalign", {31'b0, bus.misalign_o}, 32'd0);
        exp_pc = RESET_PC;
        tgt = RESET_PC;
        exp_fetch = RESET_PC;
        exp_mis = 1'b0;
        held = 1'b0;
        since = 1;
        stall_run = 0;
    endtask

    // One clock of stimulus: drive inputs, check the current cycle, then advance the model
    task automatic cycle(input logic rdy, input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        logic acc, redir;
        logic [31:0] raw;
        bus.ready_i = rdy;
        bus.pc_src = src;
        bus.imm_op = imm;
        bus.alu_result = alu;
        #1;
        acc = bus.valid_o & rdy;
        redir = acc & (src != 2'b00);
        check("misalign", {31'b0, bus.misalign_o}, {31'b0, exp_mis});
        if (since == 1) check("redir_req", {31'b0, bus.imem_req}, 32'd1);
        if (since == 1) check("redir_addr", bus.imem_addr, tgt);
        if (since == 1 || since == 2) check("redir_gap_valid", {31'b0, bus.valid_o}, 32'd0);
        if (since == 3) check("redir_latency", {31'b0, bus.valid_o}, 32'd1);
        if (bus.valid_o) check("pc", bus.pc_o, exp_pc);
        if (bus.valid_o) check("instr", bus.instr_o, mem_f(bus.pc_o));
        if (held) check("hold_pc", bus.pc_o, held_pc);
        if (held) check("hold_instr", bus.instr_o, held_instr);
        if (held) check("hold_valid", {31'b0, bus.valid_o}, 32'd1);
        if (redir) check("req_on_redirect", {31'b0, bus.imem_req}, 32'd0);
        if (!rdy && stall_run >= 2) check("req_when_full", {31'b0, bus.imem_req}, 32'd0);
        if (bus.imem_req) check("fetch_addr", bus.imem_addr, exp_fetch);
        raw = src == 2'd1 ? bus.pc_o + imm : src == 2'd2 ? imm : alu;
        held = bus.valid_o & ~rdy;
        held_pc = bus.pc_o;
        held_instr = bus.instr_o;
        stall_run = rdy ? 0 : stall_run + 1;
        exp_mis = redir & (raw[1:0] != 2'b00);
        if (redir) begin
            tgt = raw & 32'hFFFF_FFFC;
            exp_pc = tgt;
            exp_fetch = tgt;
            since = 1;
        end else begin
            if (acc) exp_pc = exp_pc + 32'd4;
            if (bus.imem_req) exp_fetch = bus.imem_addr + 32'd4;
            if (since < 10) since++;
        end
        @(negedge clk);
    endtask

    task automatic go_to(input logic [31:0] pc);
        int n = 0;
        while (!(bus.valid_o === 1'b1 && bus.pc_o === pc) && n < 60) begin
            cycle(1'b1, 2'b00, 32'h0, 32'h0);
            n++;
        end
        check("goto_valid", {31'b0, bus.valid_o}, 32'd1);
        check("goto_pc", bus.pc_o, pc);
    endtask

    initial begin
        logic [31:0] imm, alu;
        do_reset();
        go_to(32'h8);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0);
        go_to(32'h10);
        cycle(1'b1, 2'b01, 32'h20, 32'h0);
        go_to(32'h30);
        cycle(1'b1, 2'b10, 32'h100, 32'h0);
        go_to(32'h100);
        cycle(1'b1, 2'b11, 32'h0, 32'h205);
        go_to(32'h204);
        cycle(1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0);
        go_to(32'hFFFF_FFFC);
        cycle(1'b1, 2'b01, 32'h8, 32'h0);
        go_to(32'h4);
        for (int i = 0; i < 8; i++) begin
            check("throughput", {31'b0, bus.valid_o}, 32'd1);
            cycle(1'b1, 2'b00, 32'h0, 32'h0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0);
        do_reset();
        go_to(RESET_PC);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            imm = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, imm, alu);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
